// File: rtl/gate_sched_pkg.sv
// Shared state encoding and default sizing for the parking gate scheduler.
package gate_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        EXIT  = 2'd2,
        HOLD  = 2'd3
    } gate_state_e;

    localparam logic [7:0] DEF_CAPACITY     = 8'd20;
    localparam int         DEF_PASS_TIMEOUT = 16;

endpackage

// File: rtl/gate_pass_timer.sv
// Clearable pass timer: counts cycles the gate is open and flags the last allowed cycle.
module gate_pass_timer
    import gate_sched_pkg::*;
#(
    parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(PASS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PASS_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at LAST so a stalled count never wraps back into range.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Shared entry/exit gate scheduler with occupancy tracking, pass timeout and lockout.
// Define GATE_SCHED_RR_EN for round-robin tie-breaking; default is exit-lane priority.
module parking_gate_scheduler
    import gate_sched_pkg::*;
#(
    parameter logic [7:0] CAPACITY     = DEF_CAPACITY,
    parameter int         PASS_TIMEOUT = DEF_PASS_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass_sensor,
    input  logic       block_alarm,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic       open_gate,
    output logic       close_gate,
    output logic [7:0] occupancy,
    output logic       full,
    output logic       timeout_alarm
);

    gate_state_e state_q, state_d;
    logic        entry_grant_q, entry_grant_d;
    logic        exit_grant_q, exit_grant_d;
    logic        open_gate_q, open_gate_d;
    logic [7:0]  occupancy_q, occupancy_d;
    logic        timeout_alarm_q, timeout_alarm_d;
    logic        pass_prev_q;

    logic pass_edge;
    logic entry_ok;
    logic exit_ok;
    logic pick_exit;
    logic timer_clear;
    logic timer_en;
    logic expire;

    assign full      = (occupancy_q == CAPACITY);
    assign pass_edge = pass_sensor && !pass_prev_q;
    assign entry_ok  = entry_req && !full;
    assign exit_ok   = exit_req && (occupancy_q != 8'd0);

`ifdef GATE_SCHED_RR_EN
    logic rr_ptr_q, rr_ptr_d;
    logic lane_done;

    // rr_ptr_q = 0 names the entry lane, 1 names the exit lane.
    assign pick_exit = exit_ok && (!entry_ok || rr_ptr_q);
    assign lane_done = timer_en && !block_alarm && (pass_edge || expire);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (lane_done) begin
            rr_ptr_d = !rr_ptr_q;
        end
    end
`else
    assign pick_exit = exit_ok;
`endif

    assign timer_en    = (state_q == ENTRY) || (state_q == EXIT);
    assign timer_clear = (state_q == IDLE) && !block_alarm && (entry_ok || exit_ok);

    gate_pass_timer #(
        .PASS_TIMEOUT(PASS_TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .en    (timer_en),
        .expire(expire)
    );

    // Lockout outranks a pass or timeout; a pass outranks a timeout in the same cycle.
    always_comb begin
        state_d         = state_q;
        occupancy_d     = occupancy_q;
        timeout_alarm_d = 1'b0;
        if (block_alarm) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_exit) begin
                        state_d = EXIT;
                    end else if (entry_ok) begin
                        state_d = ENTRY;
                    end
                end
                ENTRY, EXIT: begin
                    if (pass_edge) begin
                        state_d = IDLE;
                        if (state_q == ENTRY) begin
                            if (occupancy_q < CAPACITY) begin
                                occupancy_d = occupancy_q + 8'd1;
                            end
                        end else if (occupancy_q != 8'd0) begin
                            occupancy_d = occupancy_q - 8'd1;
                        end
                    end else if (expire) begin
                        state_d         = IDLE;
                        timeout_alarm_d = 1'b1;
                    end
                end
                HOLD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        entry_grant_d = (state_d == ENTRY);
        exit_grant_d  = (state_d == EXIT);
        open_gate_d   = (state_d == ENTRY) || (state_d == EXIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            entry_grant_q   <= 1'b0;
            exit_grant_q    <= 1'b0;
            open_gate_q     <= 1'b0;
            occupancy_q     <= 8'd0;
            timeout_alarm_q <= 1'b0;
            pass_prev_q     <= 1'b0;
`ifdef GATE_SCHED_RR_EN
            rr_ptr_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            entry_grant_q   <= entry_grant_d;
            exit_grant_q    <= exit_grant_d;
            open_gate_q     <= open_gate_d;
            occupancy_q     <= occupancy_d;
            timeout_alarm_q <= timeout_alarm_d;
            pass_prev_q     <= pass_sensor;
`ifdef GATE_SCHED_RR_EN
            rr_ptr_q        <= rr_ptr_d;
`endif
        end
    end

    assign entry_grant   = entry_grant_q;
    assign exit_grant    = exit_grant_q;
    assign open_gate     = open_gate_q;
    assign close_gate    = !open_gate_q;
    assign occupancy     = occupancy_q;
    assign timeout_alarm = timeout_alarm_q;

endmodule

// File: doc/parking_gate_scheduler.md
PARKING_GATE_SCHEDULER -- requirements
Module: parking_gate_scheduler

Interface
REQ-001 Parameter CAPACITY, default 8'd20: maximum number of cars inside.
REQ-002 Parameter PASS_TIMEOUT, default 16: cycles allowed for a car to pass an open gate.
REQ-003 The port list SHALL be, clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- entry_req  in  1  level; the access controller has authorized an entry.
- exit_req  in  1  level; the exit lane detects a car.
- pass_sensor  in  1  level; a car is under the shared gate.
- block_alarm  in  1  level; lockout from the access controller.
- entry_grant  out  1  gate is owned by the entry lane.
- exit_grant  out  1  gate is owned by the exit lane.
- open_gate  out  1  gate open command.
- close_gate  out  1  gate close command; always the complement of open_gate.
- occupancy  out  8  number of cars inside.
- full  out  1  occupancy == CAPACITY.
- timeout_alarm  out  1  one-cycle pulse when a pass times out.

Function
REQ-004 The FSM SHALL have four states: IDLE, ENTRY, EXIT, HOLD; all outputs registered.
REQ-005 IDLE->ENTRY SHALL occur when entry_req=1 and full=0, subject to REQ-007.
REQ-006 IDLE->EXIT SHALL occur when exit_req=1 and occupancy!=0, subject to REQ-007.
REQ-007 When both requests are eligible in the same cycle, the lane SHALL be chosen by the rule in REQ-020/021.
REQ-008 Grant and open_gate SHALL assert in the cycle after the request is sampled in IDLE (1-cycle latency).
REQ-009 In ENTRY/EXIT, the state SHALL only be left through REQ-010, REQ-011 or REQ-012.
REQ-010 A pass SHALL be a rising edge of pass_sensor detected in ENTRY/EXIT; the FSM then returns to IDLE on the next edge.
- ENTRY pass: occupancy +1, saturating at CAPACITY.
- EXIT pass: occupancy -1, saturating at 0.
REQ-011 A cycle counter SHALL clear on ENTRY/EXIT entry; on reaching PASS_TIMEOUT with no pass:
- return to IDLE;
- pulse timeout_alarm for exactly one cycle;
- leave occupancy unchanged.
REQ-012 block_alarm=1 SHALL force HOLD from any state on the next edge, with priority over a pass or timeout in the same cycle; the pending pass is not counted.
REQ-013 In HOLD: open_gate=0, grants=0, occupancy frozen; HOLD->IDLE the cycle after block_alarm deasserts.
REQ-014 full SHALL be recomputed combinationally from registered occupancy; entry requests SHALL be ignored while full=1.
REQ-015 A pass_sensor rising edge in IDLE or HOLD SHALL be ignored.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL be in IDLE with the following values:
- open_gate=0, close_gate=1;
- entry_grant=0, exit_grant=0;
- occupancy=0, full=0, timeout_alarm=0;
- timeout counter=0;
- pass edge register=0;
- round-robin pointer=entry.
REQ-017 rst asserted mid-pass SHALL abort the pass without counting it.
REQ-018 rst SHALL take priority over block_alarm.

Configuration
REQ-019 Macro GATE_SCHED_RR_EN SHALL select the arbitration policy.
REQ-020 With GATE_SCHED_RR_EN defined: round-robin.
- The pointer flips to the other lane after each granted pass or timeout.
- On a tie, the lane named by the pointer wins.
REQ-021 Without GATE_SCHED_RR_EN: fixed priority; the exit lane always wins a tie, and the pointer logic is absent.

Structure
REQ-022 Shared package gate_sched_pkg SHALL hold:
- the state encoding (IDLE=2'd0, ENTRY=2'd1, EXIT=2'd2, HOLD=2'd3);
- the default CAPACITY and PASS_TIMEOUT constants.
REQ-023 One sub-module, gate_pass_timer, SHALL implement the clearable timeout counter and expire flag; the FSM, arbiter and occupancy logic stay in the top module.

Verification
REQ-024 Reset, then entry_req=1 for 1 cycle, then a pass_sensor pulse 3 cycles later -> entry_grant/open_gate high 1 cycle after the request, occupancy=1, gate closed and back in IDLE after the pass.
REQ-025 occupancy=CAPACITY(20), entry_req=1 -> full=1, no grant, open_gate stays 0; then exit_req plus a pass -> occupancy=19, full=0.
REQ-026 entry_req and exit_req both high with occupancy=5:
- RR build: entry wins, then exit wins on the next tie;
- non-RR build: exit wins both times.
REQ-027 Grant then no pass for 16 cycles -> timeout_alarm pulses once, state IDLE, occupancy unchanged.
REQ-028 block_alarm asserted in the same cycle as a pass edge during ENTRY -> HOLD, gate closed, occupancy unchanged; deassert -> IDLE one cycle later.
REQ-029 rst=1 during EXIT with occupancy=3 -> all outputs take the REQ-016 values on the next edge.
